ldpc_iter_ctrl: RTL and testbench
=================================

# ldpc_iter_ctrl

Iteration controller for the flooding-schedule binary LDPC decoder (6 variable nodes, 3 check nodes). It sequences the datapath through channel-LLR load, check-node update, variable-node update and syndrome check, and counts iterations up to a programmable limit. It terminates with a converged, exhausted or aborted status. It replaces the ad-hoc toggle-clocked latch in the decoder top level with single-clock enables and a start/done/ack handshake.

## Interface
- WIDTH, 20, width of the `max_num_iter` and `iterations_num` fields.
- CN_LAT, 1, cycles `cn_en` is held per iteration (check-node settle time), ≥1.
- VN_LAT, 1, cycles `vn_en` is held per iteration, ≥1; last cycle carries `vn_latch`.
- CHK_LAT, 1, cycles allowed for the syndrome to settle before sampling, ≥1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a decode; sampled in IDLE or DONE only.
- max_num_iter  in  WIDTH  iteration limit; captured on accepted start.
- syndrome_ok  in  1  all parity checks satisfied on the current hard decision.
- abort  in  1  terminate the current decode.
- ack  in  1  release DONE status.
- load_llr  out  1  one-cycle pulse: datapath loads channel LLRs into the vn→cn message registers.
- cn_en  out  1  check-node update window.
- vn_en  out  1  variable-node update window.
- vn_latch  out  1  one-cycle pulse: datapath registers VN outputs into the vn→cn message registers.
- sel_posterior  out  1  0 = hard decision from channel LLRs, 1 = from posterior beliefs.
- busy  out  1  high in LOAD/CN_UPD/VN_UPD/CHECK.
- done  out  2  00 running/idle, 10 converged, 01 max iterations exhausted, 11 aborted.
- iterations_num  out  WIDTH  completed iterations.

## Operation
- States: IDLE, LOAD, CHECK, CN_UPD, VN_UPD, DONE. A phase counter `ph` counts cycles within CHECK, CN_UPD and VN_UPD.
- IDLE → LOAD on `start`. Capture `max_num_iter` into `lim`. Clear `iterations_num`, `sel_posterior` and `done`.
- LOAD lasts one cycle with `load_llr`=1, then → CHECK.
- CHECK lasts CHK_LAT cycles. `syndrome_ok` is sampled only in the last cycle, and the exits are evaluated in this priority order:
  - `syndrome_ok`=1 → DONE, `done`=10.
  - else `iterations_num`==`lim` → DONE, `done`=01.
  - else → CN_UPD.
- CN_UPD holds `cn_en`=1 for CN_LAT cycles, then → VN_UPD.
- VN_UPD holds `vn_en`=1 for VN_LAT cycles. In its last cycle, `vn_latch`=1, `iterations_num` increments and `sel_posterior` is set to 1. Then → CHECK.
- DONE: `done` and `iterations_num` are held, `busy`=0.
  - `ack` → IDLE, `done` cleared.
  - `start` → LOAD, acting as an implicit ack (new decode).
  - If `start` and `ack` are both high, `start` wins.
- `abort` in any busy state → DONE with `done`=11 next edge. `abort` takes priority over a simultaneous CHECK exit. `abort` is ignored in IDLE/DONE.
- `start` while busy is ignored.
- `lim`=0 → only the channel hard decision is checked: exit 10 or 01 with `iterations_num`=0.
- `iterations_num` never exceeds `lim`, so no wrap occurs. `lim`=2^WIDTH−1 is legal.

## Timing
- Reset, and every output after an `rst` edge:
  - state IDLE.
  - `load_llr`, `cn_en`, `vn_en`, `vn_latch`, `sel_posterior`, `busy` = 0.
  - `done`=00, `iterations_num`=0.
- `rst` mid-decode aborts silently to IDLE without reporting `done`=11.
- All outputs are registered and decode from the current state/phase; no combinational input→output paths.
- With `start` accepted at edge 0:
  - LOAD occupies cycle 1.
  - CHECK occupies cycles 2..1+CHK_LAT.
  - Each iteration adds CN_LAT+VN_LAT+CHK_LAT cycles.
- `done` becomes valid at edge 2+CHK_LAT+k·(CN_LAT+VN_LAT+CHK_LAT) for k completed iterations.
- `syndrome_ok` must be valid CHK_LAT−1 cycles after CHECK entry. The datapath syndrome path must meet this.
- `vn_latch` and the `iterations_num` increment occur on the same edge. `sel_posterior` goes high on that edge and stays high until the next LOAD.

## Test plan
- All LAT=1, `lim`=5, `syndrome_ok`=1 constantly, `start` at edge 0 → one `load_llr` pulse in cycle 1; `done`=10 from edge 3; `iterations_num`=0; no `cn_en`.
- All LAT=1, `lim`=5, `syndrome_ok` rising during the 2nd iteration's CHECK → `done`=10 at edge 9; `iterations_num`=2; exactly 2 `vn_latch` pulses.
- All LAT=1, `lim`=5, `syndrome_ok`=0 always → `done`=01 at edge 18; `iterations_num`=5; `busy` low from edge 18.
- CN_LAT=2, VN_LAT=3, CHK_LAT=2, `lim`=1, `syndrome_ok`=0 → `cn_en` high 2 cycles, `vn_en` high 3 cycles, one `vn_latch` in the last `vn_en` cycle; `done`=01 at edge 2+2+7=11.
- `abort` asserted in VN_UPD of iteration 3 (`lim`=10) → `done`=11 next edge; `iterations_num`=2. Then `start` in DONE → LOAD, `done`=00, `iterations_num`=0.
- `rst` asserted in CN_UPD, `start` asserted while busy, and `lim`=0 with `syndrome_ok`=0 → reset values on the next edge; start-while-busy has no effect; `lim`=0 run gives `done`=01 at edge 3 with `iterations_num`=0.

Source files
------------

// File: rtl/ldpc_iter_ctrl_if.sv
// Handshake and control bundle between the LDPC iteration controller and
// the decoder datapath / host.
//   master: controller side (drives load_llr, cn_en, vn_en, vn_latch,
//           sel_posterior, busy, done, iterations_num)
//   slave : host/datapath side (drives start, max_num_iter, syndrome_ok,
//           abort, ack)
interface ldpc_iter_ctrl_if #(
  parameter int unsigned WIDTH = 20
);
  logic             start;
  logic [WIDTH-1:0] max_num_iter;
  logic             syndrome_ok;
  logic             abort;
  logic             ack;
  logic             load_llr;
  logic             cn_en;
  logic             vn_en;
  logic             vn_latch;
  logic             sel_posterior;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH-1:0] iterations_num;

  modport master (
    input  start, max_num_iter, syndrome_ok, abort, ack,
    output load_llr, cn_en, vn_en, vn_latch, sel_posterior, busy, done,
           iterations_num
  );

  modport slave (
    output start, max_num_iter, syndrome_ok, abort, ack,
    input  load_llr, cn_en, vn_en, vn_latch, sel_posterior, busy, done,
           iterations_num
  );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for the flooding-schedule LDPC decoder.
// Sequences LOAD -> CHECK -> (CN_UPD -> VN_UPD -> CHECK)* -> DONE and
// counts iterations against a limit captured at start.
//   clk, rst : single rising-edge clock, synchronous active-high reset
//   bus      : start/max_num_iter/syndrome_ok/abort/ack in,
//              load_llr/cn_en/vn_en/vn_latch/sel_posterior/busy/done/
//              iterations_num out
module ldpc_iter_ctrl #(
  parameter int unsigned WIDTH   = 20,
  parameter int unsigned CN_LAT  = 1,
  parameter int unsigned VN_LAT  = 1,
  parameter int unsigned CHK_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ldpc_iter_ctrl_if.master  bus
);

  localparam int unsigned LAT_AB  = (CN_LAT > VN_LAT) ? CN_LAT : VN_LAT;
  localparam int unsigned LAT_MAX = (LAT_AB > CHK_LAT) ? LAT_AB : CHK_LAT;
  localparam int unsigned PH_W    = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [PH_W-1:0] CN_LAST  = PH_W'(CN_LAT - 1);
  localparam logic [PH_W-1:0] VN_LAST  = PH_W'(VN_LAT - 1);
  localparam logic [PH_W-1:0] CHK_LAST = PH_W'(CHK_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    CN_UPD,
    VN_UPD,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [PH_W-1:0]   ph, ph_next;
  logic [WIDTH-1:0]  lim;
  logic [WIDTH-1:0]  iter_cnt;
  logic              sel_post;
  logic [1:0]        done_code;

  logic              check_last;
  logic              vn_last;
  logic              running;

  assign check_last = (state == CHECK)  && (ph == CHK_LAST);
  assign vn_last    = (state == VN_UPD) && (ph == VN_LAST);
  assign running    = (state == LOAD) || (state == CHECK) ||
                      (state == CN_UPD) || (state == VN_UPD);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph    <= '0;
    end else begin
      state <= state_next;
      ph    <= ph_next;
    end
  end

  // Next-state logic; abort overrides every exit of a running state
  always_comb begin
    state_next = state;
    ph_next    = ph;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          ph_next    = '0;
        end
      end
      LOAD: begin
        ph_next = '0;
        if (bus.abort) state_next = DONE;
        else           state_next = CHECK;
      end
      CHECK: begin
        if (bus.abort) begin
          state_next = DONE;
        end else if (ph == CHK_LAST) begin
          ph_next = '0;
          if (bus.syndrome_ok || (iter_cnt == lim)) state_next = DONE;
          else                                      state_next = CN_UPD;
        end else begin
          ph_next = ph + 1'b1;
        end
      end
      CN_UPD: begin
        if (bus.abort) begin
          state_next = DONE;
        end else if (ph == CN_LAST) begin
          state_next = VN_UPD;
          ph_next    = '0;
        end else begin
          ph_next = ph + 1'b1;
        end
      end
      VN_UPD: begin
        if (bus.abort) begin
          state_next = DONE;
        end else if (ph == VN_LAST) begin
          state_next = CHECK;
          ph_next    = '0;
        end else begin
          ph_next = ph + 1'b1;
        end
      end
      DONE: begin
        ph_next = '0;
        if (bus.start)    state_next = LOAD;
        else if (bus.ack) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        ph_next    = '0;
      end
    endcase
  end

  // Status registers: limit, iteration count, posterior select, done code
  always_ff @(posedge clk) begin
    if (rst) begin
      lim       <= '0;
      iter_cnt  <= '0;
      sel_post  <= 1'b0;
      done_code <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            lim       <= bus.max_num_iter;
            iter_cnt  <= '0;
            sel_post  <= 1'b0;
            done_code <= 2'b00;
          end else if (bus.ack) begin
            done_code <= 2'b00;
          end
        end
        default: begin
          // an abort in the last VN cycle suppresses that iteration's count
          if (bus.abort) begin
            done_code <= 2'b11;
          end else begin
            if (check_last) begin
              if (bus.syndrome_ok)    done_code <= 2'b10;
              else if (iter_cnt == lim) done_code <= 2'b01;
            end
            if (vn_last) begin
              iter_cnt <= iter_cnt + WIDTH'(1);
              sel_post <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output decode from registered state/phase only
  always_comb begin
    bus.load_llr       = (state == LOAD);
    bus.cn_en          = (state == CN_UPD);
    bus.vn_en          = (state == VN_UPD);
    bus.vn_latch       = vn_last;
    bus.busy           = running;
    bus.sel_posterior  = sel_post;
    bus.done           = done_code;
    bus.iterations_num = iter_cnt;
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
module tb_ldpc_iter_ctrl;

  logic clk;
  logic rst;

  int unsigned n_cmp;
  int unsigned n_err;

  int unsigned a_load, a_cn, a_vn, a_latch;
  int unsigned b_cn, b_vn, b_latch;

  ldpc_iter_ctrl_if #(.WIDTH(20)) ifa ();
  ldpc_iter_ctrl_if #(.WIDTH(20)) ifb ();

  ldpc_iter_ctrl #(
    .WIDTH(20), .CN_LAT(1), .VN_LAT(1), .CHK_LAT(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  ldpc_iter_ctrl #(
    .WIDTH(20), .CN_LAT(2), .VN_LAT(3), .CHK_LAT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    a_load = 0; a_cn = 0; a_vn = 0; a_latch = 0;
    b_cn = 0; b_vn = 0; b_latch = 0;
  endtask

  // One clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifa.load_llr === 1'b1) a_load++;
    if (ifa.cn_en    === 1'b1) a_cn++;
    if (ifa.vn_en    === 1'b1) a_vn++;
    if (ifa.vn_latch === 1'b1) a_latch++;
    if (ifb.cn_en    === 1'b1) b_cn++;
    if (ifb.vn_en    === 1'b1) b_vn++;
    if (ifb.vn_latch === 1'b1) b_latch++;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_counts();
    rst = 1'b1;
    ifa.start = 1'b0; ifa.max_num_iter = '0; ifa.syndrome_ok = 1'b0;
    ifa.abort = 1'b0; ifa.ack = 1'b0;
    ifb.start = 1'b0; ifb.max_num_iter = '0; ifb.syndrome_ok = 1'b0;
    ifb.abort = 1'b0; ifb.ack = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy",  ifa.busy, 0);
    chk("rst_done",  ifa.done, 0);
    chk("rst_iter",  ifa.iterations_num, 0);
    chk("rst_load",  ifa.load_llr, 0);
    chk("rst_sel",   ifa.sel_posterior, 0);
    chk("rst_b_cn",  ifb.cn_en, 0);
    rst = 1'b0;
    tick();

    // Converge on the channel hard decision
    ifa.max_num_iter = 20'd5;
    ifa.syndrome_ok  = 1'b1;
    ifa.start        = 1'b1;
    clr_counts();
    tick();
    ifa.start = 1'b0;
    chk("t1_load_e1", ifa.load_llr, 1);
    chk("t1_busy_e1", ifa.busy, 1);
    tick();
    chk("t1_load_e2", ifa.load_llr, 0);
    tick();
    chk("t1_done_e3", ifa.done, 2'b10);
    chk("t1_iter",    ifa.iterations_num, 0);
    chk("t1_busy_e3", ifa.busy, 0);
    chk("t1_nload",   a_load, 1);
    chk("t1_ncn",     a_cn, 0);
    ifa.ack = 1'b1;
    tick();
    ifa.ack = 1'b0;
    chk("t1_ack_done", ifa.done, 0);
    chk("t1_ack_busy", ifa.busy, 0);

    // Converge during the 2nd iteration's CHECK
    ifa.syndrome_ok = 1'b0;
    ifa.start       = 1'b1;
    clr_counts();
    tick();
    ifa.start = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (i == 4) begin
        chk("t2_latch_e4", ifa.vn_latch, 1);
        chk("t2_sel_e4",   ifa.sel_posterior, 0);
      end
      if (i == 5) begin
        chk("t2_sel_e5",  ifa.sel_posterior, 1);
        chk("t2_iter_e5", ifa.iterations_num, 1);
      end
    end
    ifa.syndrome_ok = 1'b1;
    tick();
    ifa.syndrome_ok = 1'b0;
    chk("t2_done_e9", ifa.done, 2'b10);
    chk("t2_iter",    ifa.iterations_num, 2);
    chk("t2_nlatch",  a_latch, 2);
    chk("t2_sel",     ifa.sel_posterior, 1);
    ifa.ack = 1'b1;
    tick();
    ifa.ack = 1'b0;

    // Exhaust the iteration limit
    ifa.start = 1'b1;
    clr_counts();
    tick();
    ifa.start = 1'b0;
    for (int i = 2; i <= 17; i++) tick();
    chk("t3_busy_e17", ifa.busy, 1);
    chk("t3_done_e17", ifa.done, 0);
    tick();
    chk("t3_done_e18", ifa.done, 2'b01);
    chk("t3_iter",     ifa.iterations_num, 5);
    chk("t3_busy_e18", ifa.busy, 0);
    chk("t3_nlatch",   a_latch, 5);
    ifa.ack = 1'b1;
    tick();
    ifa.ack = 1'b0;

    // Longer latencies on the second instance, lim = 1
    ifb.max_num_iter = 20'd1;
    ifb.syndrome_ok  = 1'b0;
    ifb.start        = 1'b1;
    clr_counts();
    tick();
    ifb.start = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (i == 7) chk("t4_latch_e7", ifb.vn_latch, 0);
      if (i == 8) begin
        chk("t4_latch_e8", ifb.vn_latch, 1);
        chk("t4_vnen_e8",  ifb.vn_en, 1);
      end
    end
    chk("t4_done_e10", ifb.done, 0);
    tick();
    chk("t4_done_e11", ifb.done, 2'b01);
    chk("t4_iter",     ifb.iterations_num, 1);
    chk("t4_ncn",      b_cn, 2);
    chk("t4_nvn",      b_vn, 3);
    chk("t4_nlatch",   b_latch, 1);
    ifb.ack = 1'b1;
    tick();
    ifb.ack = 1'b0;

    // Abort in VN_UPD of iteration 3, then restart from DONE
    ifa.max_num_iter = 20'd10;
    ifa.start        = 1'b1;
    clr_counts();
    tick();
    ifa.start = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    chk("t5_vnen_e10", ifa.vn_en, 1);
    chk("t5_iter_e10", ifa.iterations_num, 2);
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("t5_done_abort", ifa.done, 2'b11);
    chk("t5_iter_abort", ifa.iterations_num, 2);
    chk("t5_busy_abort", ifa.busy, 0);
    ifa.start = 1'b1;
    tick();
    chk("t5_restart_load", ifa.load_llr, 1);
    chk("t5_restart_done", ifa.done, 0);
    chk("t5_restart_iter", ifa.iterations_num, 0);
    chk("t5_restart_sel",  ifa.sel_posterior, 0);

    // start held while busy, then reset in CN_UPD of iteration 2
    clr_counts();
    for (int i = 2; i <= 6; i++) tick();
    ifa.start = 1'b0;
    chk("t6_cnen_e6",  ifa.cn_en, 1);
    chk("t6_iter_e6",  ifa.iterations_num, 1);
    chk("t6_nload",    a_load, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", ifa.busy, 0);
    chk("t6_rst_cn",   ifa.cn_en, 0);
    chk("t6_rst_done", ifa.done, 0);
    chk("t6_rst_iter", ifa.iterations_num, 0);
    chk("t6_rst_sel",  ifa.sel_posterior, 0);
    tick();
    chk("t6_idle_busy", ifa.busy, 0);

    // lim = 0 : only the channel hard decision is checked
    ifa.max_num_iter = 20'd0;
    ifa.syndrome_ok  = 1'b0;
    ifa.start        = 1'b1;
    clr_counts();
    tick();
    ifa.start = 1'b0;
    tick();
    chk("t7_done_e2", ifa.done, 0);
    tick();
    chk("t7_done_e3", ifa.done, 2'b01);
    chk("t7_iter",    ifa.iterations_num, 0);
    chk("t7_ncn",     a_cn, 0);
    chk("t7_busy",    ifa.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
